// File: rtl/ads1675_receiver_if.sv
// Pin and sample-stream bundle between the ADS1675 CMOS-mode serial port and its receiver.
// master is the receiver side; slave is the ADC / downstream consumer side.
interface ads1675_receiver_if #(
    parameter int DW = 24
);
    logic                 sclk;
    logic                 drdy;
    logic                 dout;
    logic                 dr0;
    logic                 dr1;
    logic                 dr2;
    logic                 fpath;
    logic                 ll_cfg;
    logic                 lvds;
    logic                 clk_sel;
    logic                 cs_n;
    logic                 start;
    logic                 pown;
    logic signed [DW-1:0] data;
    logic                 valid;

    modport master (
        input  sclk, drdy, dout,
        output dr0, dr1, dr2, fpath, ll_cfg, lvds, clk_sel,
        output cs_n, start, pown,
        output data, valid
    );

    modport slave (
        output sclk, drdy, dout,
        input  dr0, dr1, dr2, fpath, ll_cfg, lvds, clk_sel,
        input  cs_n, start, pown,
        input  data, valid
    );
endinterface

// File: rtl/ads1675_receiver.sv
// ADS1675 CMOS-mode serial receiver: drives static config/control pins, frames on the
// DRDY rising edge and shifts DW bits MSB-first from DOUT into a signed sample word.

module counter #(
    parameter int M = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic co
);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] cnt_r;

    // Modulo-M count; reset takes priority over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign co = en & (cnt_r == LAST);
endmodule

module ads1675_receiver #(
    parameter int         DW      = 24,
    parameter logic [2:0] DR      = 3'b000,
    parameter logic       FPATH   = 1'b0,
    parameter logic       LL_CFG  = 1'b0,
    parameter logic       CLK_SEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    ads1675_receiver_if.master   bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_r;
    logic                 drdy_d_r;
    logic [DW-2:0]        sr_r;
    logic signed [DW-1:0] data_r;
    logic                 valid_r;
    logic                 cs_n_r;
    logic                 start_r;
    logic                 pown_r;

    logic                 rise_s;
    logic                 co_s;
    logic                 cnt_en_s;
    logic                 cnt_clr_s;
    logic                 cnt_rst_n_s;
    logic [DW-1:0]        word_s;

    assign rise_s = bus.drdy & ~drdy_d_r;
    assign word_s = {sr_r, bus.dout};

    // Counter runs only while shifting; it is cleared whenever a new frame is entered
    always_comb begin
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_en_s  = 1'b0;
                cnt_clr_s = en & rise_s;
            end
            SHIFT: begin
                cnt_en_s  = en;
                cnt_clr_s = en & rise_s & co_s;
            end
            default: begin
                cnt_en_s  = 1'b0;
                cnt_clr_s = 1'b0;
            end
        endcase
    end

    assign cnt_rst_n_s = rst_n & ~cnt_clr_s;

    counter #(.M(DW)) u_bit_cnt (
        .clk   (clk),
        .rst_n (cnt_rst_n_s),
        .en    (cnt_en_s),
        .co    (co_s)
    );

    // Frame FSM, shift register, output word and control pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            drdy_d_r <= 1'b0;
            sr_r     <= '0;
            data_r   <= '0;
            valid_r  <= 1'b0;
            cs_n_r   <= 1'b1;
            start_r  <= 1'b0;
            pown_r   <= 1'b0;
        end else if (en) begin
            drdy_d_r <= bus.drdy;
            cs_n_r   <= 1'b0;
            start_r  <= 1'b1;
            pown_r   <= 1'b1;
            valid_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    sr_r <= word_s[DW-2:0];
                    if (co_s) begin
                        data_r  <= word_s;
                        valid_r <= 1'b1;
                        // A rise on the LSB cycle is the next back-to-back frame
                        state_r <= rise_s ? SHIFT : IDLE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.data    = data_r;
    assign bus.valid   = valid_r;
    assign bus.cs_n    = cs_n_r;
    assign bus.start   = start_r;
    assign bus.pown    = pown_r;
    assign bus.dr0     = DR[0];
    assign bus.dr1     = DR[1];
    assign bus.dr2     = DR[2];
    assign bus.fpath   = FPATH;
    assign bus.ll_cfg  = LL_CFG;
    assign bus.clk_sel = CLK_SEL;
    assign bus.lvds    = 1'b0;
endmodule

// File: tb/tb_ads1675_receiver.sv
// Randomized scoreboard bench for ads1675_receiver: a slot-level stimulus schedule
// predicts each word and the cycle it must appear; a negedge monitor checks the DUT.
module tb_ads1675_receiver;
    localparam int         DW       = 24;
    localparam logic [2:0] DR_P     = 3'b101;
    localparam logic       FPATH_P  = 1'b1;
    localparam logic       LL_P     = 1'b0;
    localparam logic       CLKSEL_P = 1'b1;
    localparam int         NS       = 400;

    typedef struct {
        logic [DW-1:0] word;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic c_rst_n = 1'b0;
    logic c_en = 1'b0;
    logic c_co;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t sb_q[$];

    logic s_drdy [NS];
    logic s_dout [NS];
    logic s_rstn [NS];
    int   s_len;
    int   stall_slot;
    int   stall_len;
    int   fr_slot[$];
    logic [DW-1:0] fr_word[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ads1675_receiver_if #(.DW(DW)) bus();
    assign bus.sclk = clk;

    ads1675_receiver #(
        .DW(DW), .DR(DR_P), .FPATH(FPATH_P), .LL_CFG(LL_P), .CLK_SEL(CLKSEL_P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus)
    );

    counter #(.M(3)) u_cnt (
        .clk   (clk),
        .rst_n (c_rst_n),
        .en    (c_en),
        .co    (c_co)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every valid strobe must match the oldest expected word and its cycle
    always @(negedge clk) begin
        exp_t e;
        if (bus.valid === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid cyc=%0d data=%h required no strobe", cyc, bus.data);
            end else begin
                e = sb_q.pop_front();
                if (bus.data !== e.word || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL frame_word actual data=%h cyc=%0d required data=%h cyc=%0d",
                             bus.data, cyc, e.word, e.cyc);
                end
            end
        end
    end

    task automatic sched_clear();
        for (int i = 0; i < NS; i++) begin
            s_drdy[i] = 1'b0;
            s_dout[i] = 1'b0;
            s_rstn[i] = 1'b1;
        end
        s_len = 0;
        stall_slot = -1;
        stall_len = 0;
        fr_slot.delete();
        fr_word.delete();
    endtask

    // Frame starting at slot st: drdy high for hi slots, MSB on dout one slot later
    task automatic add_frame(input int st, input logic [DW-1:0] w, input int hi, input bit expect_it);
        for (int i = 0; i < hi; i++) s_drdy[st + i] = 1'b1;
        for (int i = 0; i < DW; i++) s_dout[st + 1 + i] = w[DW-1-i];
        if (expect_it) begin
            fr_slot.push_back(st);
            fr_word.push_back(w);
        end
        if (st + hi > s_len) s_len = st + hi;
        if (st + DW + 2 > s_len) s_len = st + DW + 2;
    endtask

    task automatic play();
        int   base;
        exp_t e;
        @(posedge clk); #1;
        base = cyc;
        for (int f = 0; f < fr_slot.size(); f++) begin
            e.word = fr_word[f];
            e.cyc  = base + fr_slot[f] + DW + 1;
            if (stall_slot >= 0 && stall_slot <= fr_slot[f] + DW) e.cyc += stall_len;
            sb_q.push_back(e);
        end
        for (int s = 0; s < s_len; s++) begin
            if (s == stall_slot) begin
                for (int j = 0; j < stall_len; j++) begin
                    en = 1'b0;
                    @(posedge clk); #1;
                end
            end
            en       = 1'b1;
            rst_n    = s_rstn[s];
            bus.drdy = s_drdy[s];
            bus.dout = s_dout[s];
            if (s > 0 && !s_rstn[s-1]) begin
                @(negedge clk);
                chk("midreset_data", 32'(bus.data), 32'h0);
                chk("midreset_valid", 32'(bus.valid), 32'h0);
                chk("midreset_cs_n", 32'(bus.cs_n), 32'h1);
            end
            @(posedge clk); #1;
        end
        bus.drdy = 1'b0;
        bus.dout = 1'b0;
        rst_n    = 1'b1;
        en       = 1'b1;
    endtask

    initial begin
        int            st;
        int            m;
        logic [DW-1:0] w;
        logic [19:0]   p_en;
        logic [19:0]   p_rst;

        bus.drdy = 1'b0;
        bus.dout = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data", 32'(bus.data), 32'h0);
        chk("reset_valid", 32'(bus.valid), 32'h0);
        chk("reset_cs_n", 32'(bus.cs_n), 32'h1);
        chk("reset_start", 32'(bus.start), 32'h0);
        chk("reset_pown", 32'(bus.pown), 32'h0);
        chk("reset_dr", 32'({bus.dr2, bus.dr1, bus.dr0}), 32'(DR_P));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("run_cs_n", 32'(bus.cs_n), 32'h0);
        chk("run_start", 32'(bus.start), 32'h1);
        chk("run_pown", 32'(bus.pown), 32'h1);
        chk("run_lvds", 32'(bus.lvds), 32'h0);
        chk("run_dr", 32'({bus.dr2, bus.dr1, bus.dr0}), 32'(DR_P));
        chk("run_cfg", 32'({bus.fpath, bus.ll_cfg, bus.clk_sel}), 32'({FPATH_P, LL_P, CLKSEL_P}));

        // single frame
        sched_clear();
        add_frame(2, 24'h5A3C96, 4, 1'b1);
        play();

        // continuous DW-periodic stream, extreme values
        sched_clear();
        add_frame(2,  24'h800000, 4, 1'b1);
        add_frame(26, 24'h7FFFFF, 4, 1'b1);
        add_frame(50, 24'h000001, 4, 1'b1);
        add_frame(74, 24'hFFFFFF, 4, 1'b1);
        play();

        // enable dropped for 5 cycles mid-frame
        sched_clear();
        w = DW'($urandom());
        add_frame(2, w, 4, 1'b1);
        stall_slot = 15;
        stall_len  = 5;
        play();

        // reset during bit 10 discards the frame; the next one is received
        sched_clear();
        w = DW'($urandom());
        add_frame(2, w, 4, 1'b0);
        s_rstn[2 + 1 + 10] = 1'b0;
        add_frame(40, 24'h123456, 4, 1'b1);
        play();

        // drdy held high, stray rise inside a frame, then a back-to-back frame
        sched_clear();
        add_frame(2, DW'($urandom()), 30, 1'b1);
        add_frame(40, DW'($urandom()), 4, 1'b1);
        s_drdy[52] = 1'b1;
        add_frame(64, DW'($urandom()), 2, 1'b1);
        play();

        // random stream: random spacing >= DW, random drdy width, random words
        sched_clear();
        st = 2;
        for (int f = 0; f < 8; f++) begin
            add_frame(st, DW'($urandom()), int'($urandom_range(1, 4)), 1'b1);
            st += DW + int'($urandom_range(0, 6));
        end
        play();

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        // counter unit test, M=3: co = en && (enabled edges since reset mod 3 == 2)
        p_en  = 20'b11111_1_1111_000_1111111;
        p_rst = 20'b11111_0_1111_111_1111111;
        c_rst_n = 1'b0;
        c_en    = 1'b1;
        @(posedge clk); #1;
        m = 0;
        for (int i = 0; i < 20; i++) begin
            c_rst_n = p_rst[i];
            c_en    = p_en[i];
            @(negedge clk);
            chk("counter_co", 32'(c_co), 32'(c_en && (m == 2)));
            @(posedge clk);
            if (!c_rst_n) m = 0;
            else if (c_en) m = (m + 1) % 3;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
